pipe_reg_destino: RTL and testbench

PIPE_REG_DESTINO -- requirements
Module: pipe_reg_destino

---
 rtl/pipe_reg_destino.sv | 75 +++++++
 tb/tb_pipe_reg_destino.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_destino.sv
// EX/MEM and MEM/WB destination-register pipeline with forwarding selects and load-use detection.
// Define PIPE_REG_DESTINO_FORWARD_EN to build in forwarding/hazard logic; otherwise those outputs are tied to 0.
module pipe_reg_destino (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] reg_destino,
  input  logic       escreve_reg,
  input  logic       mem_para_reg,
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic       stall,
  input  logic       flush,
  output logic [4:0] dest_mem,
  output logic       escreve_mem,
  output logic       load_mem,
  output logic [4:0] dest_wb,
  output logic       escreve_wb,
  output logic [1:0] encaminha_a,
  output logic [1:0] encaminha_b,
  output logic       bolha
);

  // Flush beats stall for EX/MEM; a write to $0 is dropped at capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dest_mem    <= 5'd0;
      escreve_mem <= 1'b0;
      load_mem    <= 1'b0;
    end else if (flush) begin
      dest_mem    <= 5'd0;
      escreve_mem <= 1'b0;
      load_mem    <= 1'b0;
    end else if (!stall) begin
      dest_mem    <= reg_destino;
      escreve_mem <= escreve_reg && (reg_destino != 5'd0);
      load_mem    <= mem_para_reg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dest_wb    <= 5'd0;
      escreve_wb <= 1'b0;
    end else if (!stall) begin
      dest_wb    <= dest_mem;
      escreve_wb <= escreve_mem;
    end
  end

`ifdef PIPE_REG_DESTINO_FORWARD_EN
  // A load in MEM cannot forward, so its source falls through to the WB check.
  function automatic logic [1:0] select_fwd(input logic [4:0] src);
    if (src != 5'd0 && escreve_mem && !load_mem && dest_mem == src)
      return 2'b10;
    else if (src != 5'd0 && escreve_wb && dest_wb == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    encaminha_a = select_fwd(rs_ex);
    encaminha_b = select_fwd(rt_ex);
    bolha       = escreve_mem && load_mem && (dest_mem != 5'd0) &&
                  ((dest_mem == rs_ex) || (dest_mem == rt_ex));
  end
`else
  logic unused_src;
  assign unused_src  = ^{rs_ex, rt_ex};
  assign encaminha_a = 2'b00;
  assign encaminha_b = 2'b00;
  assign bolha       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_reg_destino.sv
// Directed bench for pipe_reg_destino; forwarding expectations follow PIPE_REG_DESTINO_FORWARD_EN.
module tb_pipe_reg_destino;

`ifdef PIPE_REG_DESTINO_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] reg_destino, rs_ex, rt_ex, dest_mem, dest_wb;
  logic       escreve_reg, mem_para_reg, stall, flush;
  logic       escreve_mem, load_mem, escreve_wb, bolha;
  logic [1:0] encaminha_a, encaminha_b;
  int         checks = 0;
  int         errors = 0;

  pipe_reg_destino dut (
    .clock(clock), .reset(reset), .reg_destino(reg_destino), .escreve_reg(escreve_reg),
    .mem_para_reg(mem_para_reg), .rs_ex(rs_ex), .rt_ex(rt_ex), .stall(stall), .flush(flush),
    .dest_mem(dest_mem), .escreve_mem(escreve_mem), .load_mem(load_mem), .dest_wb(dest_wb),
    .escreve_wb(escreve_wb), .encaminha_a(encaminha_a), .encaminha_b(encaminha_b), .bolha(bolha)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [4:0] d, input logic w, input logic ld,
                               input logic s, input logic f);
    reg_destino  = d;
    escreve_reg  = w;
    mem_para_reg = ld;
    stall        = s;
    flush        = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkStages(input string tag, input logic [4:0] dm, input logic em, input logic lm,
                             input logic [4:0] dw, input logic ew);
    checkOutput({tag, ".dest_mem"}, {3'b0, dest_mem}, {3'b0, dm});
    checkOutput({tag, ".escreve_mem"}, {7'b0, escreve_mem}, {7'b0, em});
    checkOutput({tag, ".load_mem"}, {7'b0, load_mem}, {7'b0, lm});
    checkOutput({tag, ".dest_wb"}, {3'b0, dest_wb}, {3'b0, dw});
    checkOutput({tag, ".escreve_wb"}, {7'b0, escreve_wb}, {7'b0, ew});
  endtask

  task automatic checkFwd(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic bo);
    checkOutput({tag, ".encaminha_a"}, {6'b0, encaminha_a}, FWD ? {6'b0, fa} : 8'h00);
    checkOutput({tag, ".encaminha_b"}, {6'b0, encaminha_b}, FWD ? {6'b0, fb} : 8'h00);
    checkOutput({tag, ".bolha"}, {7'b0, bolha}, FWD ? {7'b0, bo} : 8'h00);
  endtask

  initial begin
    reset = 1'b0;
    rs_ex = 5'd0;
    rt_ex = 5'd0;
    applyStimulus(5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkStages("reset_hold", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkFwd("reset_hold", 2'b00, 2'b00, 1'b0);

    // Basic pipeline flow
    reset = 1'b1;
    applyStimulus(5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkStages("pipe_e1", 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkStages("pipe_e2", 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);
    tick();
    checkStages("pipe_e3", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Forwarding priority
    applyStimulus(5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rs_ex = 5'd5;
    rt_ex = 5'd0;
    #1 checkStages("fwd_mem", 5'd5, 1'b1, 1'b0, 5'd5, 1'b1);
    checkFwd("fwd_mem", 2'b10, 2'b00, 1'b0);
    applyStimulus(5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    rs_ex = 5'd0;
    rt_ex = 5'd5;
    #1 checkFwd("fwd_wb", 2'b00, 2'b01, 1'b0);

    // Load-use hazard
    applyStimulus(5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rt_ex = 5'd12;
    #1 checkStages("load_use", 5'd12, 1'b1, 1'b1, 5'd9, 1'b1);
    checkFwd("load_use", 2'b00, 2'b00, 1'b1);
    rt_ex = 5'd13;
    #1 checkFwd("load_nomatch", 2'b00, 2'b00, 1'b0);
    rs_ex = 5'd12;
    rt_ex = 5'd9;
    #1 checkFwd("load_rs_wbfb", 2'b00, 2'b01, 1'b1);

    // Register zero is never written
    applyStimulus(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    rs_ex = 5'd0;
    rt_ex = 5'd0;
    #1 checkStages("reg_zero", 5'd0, 1'b0, 1'b0, 5'd12, 1'b1);
    checkFwd("reg_zero", 2'b00, 2'b00, 1'b0);

    // Stall and flush combinations
    applyStimulus(5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkStages("pre_sf", 5'd7, 1'b1, 1'b0, 5'd3, 1'b1);
    applyStimulus(5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checkStages("stall_flush", 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    applyStimulus(5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkStages("resume", 5'd6, 1'b1, 1'b1, 5'd0, 1'b0);
    applyStimulus(5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkStages("stall_only", 5'd6, 1'b1, 1'b1, 5'd0, 1'b0);
    applyStimulus(5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkStages("flush_only", 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);

    // Asynchronous reset mid-stall
    applyStimulus(5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd15, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkStages("pre_reset", 5'd15, 1'b1, 1'b1, 5'd4, 1'b1);
    rs_ex = 5'd4;
    rt_ex = 5'd15;
    applyStimulus(5'd15, 1'b1, 1'b1, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1 checkStages("async_reset", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkFwd("async_reset", 2'b00, 2'b00, 1'b0);
    tick();
    checkStages("reset_edge", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkStages("first_capture", 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
